// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, serializer state encoding,
// frame bit counts and the parity helper.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 11-bit frame).
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 104;
  localparam int unsigned DATA_BITS        = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head entry.
// Writes while full and reads while empty are ignored.
module uart_byte_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH == 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: ready/valid byte input, FIFO, 8N1 serializer.
// Optional feature macro: UART_TX_PARITY_EN (even parity after bit 7).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  output logic            busy,
  output logic [ADDR_W:0] fifo_count
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t      state, state_n;
  logic [CW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx_q, tx_n;
  logic           pop;
  logic           baud_end;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     head;
`ifdef UART_TX_PARITY_EN
  logic           par, par_n;
`endif

  uart_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state != S_IDLE) || (fifo_count != '0);
  assign baud_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // State, timing and the registered line driver. tx is taken from the
  // current state, so the line lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

  // Next-state, pop request and line level for the serializer.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          par_n   = even_parity(head);
`endif
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        tx_n = shift[0];
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = {1'b0, shift[7:1]};
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_n = par;
        if (baud_end) begin
          baud_n  = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_n = 1'b1;
        if (baud_end) begin
          baud_n = '0;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = head;
`ifdef UART_TX_PARITY_EN
            par_n   = even_parity(head);
`endif
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        baud_n  = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed testbench for uart_tx_buffered with a bench-side UART receiver.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int unsigned CPB  = 104;
  localparam int unsigned FB   = FRAME_BITS;
  localparam int unsigned FLEN = FB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16),
    .ADDR_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Bench receiver: mid-bit sampling, records byte, start cycle, parity bit.
  bit          rx_en = 1'b0;
  logic [7:0]  rx_q [$];
  int unsigned rx_t [$];
  logic        rx_par [$];
  int          frame_err = 0;

  initial begin
    forever begin : mon
      logic [7:0]  b;
      int unsigned t0;
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB/2) @(negedge clk);
        if (tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        rx_par.push_back(tx);
`endif
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    rx_par.delete();
  endtask

  // Expected line levels of a frame, bit 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  initial begin
    string       msg;
    logic [10:0] fr;
    int          bad;
    logic [7:0]  got;

    msg = "ENIGMA READY\r\n> Z";

    // Reset and idle line
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    rst = 1'b0;
    rx_en = 1'b1;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single byte 0x41: exact latency and bit pattern
    tx_data = 8'h41; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("a_count1", {27'd0, fifo_count}, 32'd1);
    check("a_tx_n", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("a_count0", {27'd0, fifo_count}, 32'd0);
    check("a_busy", {31'd0, busy}, 32'd1);
    check("a_tx_n1", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("a_tx_fall", {31'd0, tx}, 32'd0);
    fr = frame_of(8'h41);
    repeat (CPB/2) @(negedge clk);
    for (int k = 0; k < FB; k++) begin
      check($sformatf("a_bit%0d", k), {31'd0, tx}, {31'd0, fr[k]});
      if (k < FB - 1) repeat (CPB) @(negedge clk);
    end
    repeat (CPB - CPB/2 - 2) @(negedge clk);
    check("a_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("a_busy_drop", {31'd0, busy}, 32'd0);
    check("a_rx_n", rx_q.size(), 1);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    check("a_rx_byte", {24'd0, got}, 32'h41);
    clear_rx();

    // Banner burst: one byte is popped after the first write, so 16 writes
    // leave 15 buffered; a 17th fills the FIFO.
    for (int i = 0; i < 16; i++) begin
      tx_data = msg[i]; tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("burst_count15", {27'd0, fifo_count}, 32'd15);
    check("burst_ready15", {31'd0, tx_ready}, 32'd1);
    tx_data = msg[16]; tx_valid = 1'b1;
    @(negedge clk);
    check("burst_count16", {27'd0, fifo_count}, 32'd16);
    check("burst_full", {31'd0, tx_ready}, 32'd0);

    // Writes while full are ignored
    tx_data = 8'hFF; tx_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_count !== 5'd16 || tx_ready !== 1'b0) bad++;
    end
    tx_valid = 1'b0;
    check("full_hold", bad, 0);

    wait_idle(17 * FLEN + 200);
    repeat (5) @(negedge clk);
    check("burst_rx_n", rx_q.size(), 17);
    for (int i = 0; i < 17; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("burst_byte%0d", i), {24'd0, got}, {24'd0, msg[i]});
    end
    bad = 0;
    for (int i = 1; i < rx_t.size(); i++)
      if (rx_t[i] - rx_t[i-1] != FLEN) bad++;
    check("burst_gaps", bad, 0);
    check("burst_span", (rx_t.size() == 17) ? rx_t[16] - rx_t[0] : 0, 16 * FLEN);
    clear_rx();

    // Reset during data bit 3 of 0x55 (bit 3 = 0)
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (2 + 4*CPB + CPB/2 - 1) @(negedge clk);
    check("mid_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (1100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("mid_quiet", bad, 0);
    clear_rx();

    tx_data = 8'h0D; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(FLEN + 100);
    repeat (5) @(negedge clk);
    check("cr_rx_n", rx_q.size(), 1);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    check("cr_rx_byte", {24'd0, got}, 32'h0D);

`ifdef UART_TX_PARITY_EN
    clear_rx();
    tx_data = 8'h43; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(FLEN + 100);
    repeat (5) @(negedge clk);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    check("par_byte", {24'd0, got}, 32'h43);
    check("par_bit", (rx_par.size() > 0) ? {31'd0, rx_par[0]} : 32'hx, 32'd1);
`endif

    check("frame_err", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
